// File: rtl/phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// phase_sequencer_if
//
// Purpose: bundles the control and status signals of the phase sequencer so
// that a controller (master) and the sequencer (slave) share one port.
//
// Signals:
//   start       master -> slave  one-cycle request to begin / restart a run
//   abort       master -> slave  forces an immediate return to IDLE
//   stage_done  master -> slave  [0] mem, [1] pe, [2] 3b3, [3] 2b2 done
//   rst_mem     slave -> master  1 = mem stage held in reset
//   rst_pe      slave -> master  1 = pe stage held in reset
//   rst_3b3     slave -> master  1 = 3b3 stage held in reset
//   rst_2b2     slave -> master  1 = 2b2 stage held in reset
//   rst_disp    slave -> master  1 = display stage held in reset
//   phase       slave -> master  encoded current state
//   busy        slave -> master  run in progress
//   error       slave -> master  hang detected
// ---------------------------------------------------------------------------
interface phase_sequencer_if;
  logic       start;
  logic       abort;
  logic [3:0] stage_done;
  logic       rst_mem;
  logic       rst_pe;
  logic       rst_3b3;
  logic       rst_2b2;
  logic       rst_disp;
  logic [2:0] phase;
  logic       busy;
  logic       error;

  modport master (
    output start,
    output abort,
    output stage_done,
    input  rst_mem,
    input  rst_pe,
    input  rst_3b3,
    input  rst_2b2,
    input  rst_disp,
    input  phase,
    input  busy,
    input  error
  );

  modport slave (
    input  start,
    input  abort,
    input  stage_done,
    output rst_mem,
    output rst_pe,
    output rst_3b3,
    output rst_2b2,
    output rst_disp,
    output phase,
    output busy,
    output error
  );
endinterface

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
//
// Purpose: walks a four-stage pipeline (mem -> pe -> 3b3 -> 2b2) out of reset
// one stage at a time and then releases the display stage. Each stage must
// dwell at least two cycles and leaves when its done flag is seen. An
// optional watchdog sends a stage that never finishes to an error state.
//
// Parameters:
//   TIMEOUT  cycles a stage may run before it is declared hung (2..2^24-1)
//   CNT_W    width of the dwell/timeout counter
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-low reset
//   bus      phase_sequencer_if.slave: start/abort/stage_done in,
//            stage holds, phase, busy and error out (all registered)
//
// Configuration macro:
//   PHASE_SEQ_TIMEOUT_EN  when defined, a stage that reaches TIMEOUT-1
//                         counted cycles without its done goes to ERR.
//                         When undefined, ERR is unreachable, error stays 0
//                         and stages wait forever.
// ---------------------------------------------------------------------------
module phase_sequencer #(
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned CNT_W   = 24
) (
  input  logic             clk,
  input  logic             rst,
  phase_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MEM  = 3'd1,
    PE   = 3'd2,
    C3   = 3'd3,
    C2   = 3'd4,
    DISP = 3'd5,
    ERR  = 3'd6
  } state_t;

`ifdef PHASE_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Hold patterns, bit order {mem, pe, 3b3, 2b2, disp}.
  localparam logic [4:0] HOLD_ALL  = 5'b11111;
  localparam logic [4:0] HOLD_MEM  = 5'b01111;
  localparam logic [4:0] HOLD_PE   = 5'b00111;
  localparam logic [4:0] HOLD_C3   = 5'b00011;
  localparam logic [4:0] HOLD_C2   = 5'b00001;
  localparam logic [4:0] HOLD_NONE = 5'b00000;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       hold_q, hold_d;
  logic [2:0]       phase_q, phase_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;

  logic             dwell_ok;
  logic             timeout_hit;

  // A done flag only counts once the stage has spent one full cycle in
  // place, which gives every stage a minimum dwell of two cycles.
  assign dwell_ok    = (cnt_q != '0);
  assign timeout_hit = TIMEOUT_EN && (cnt_q == TMO_LAST);

  // Next-state logic. A qualifying done is checked before the watchdog so
  // that a stage finishing on its last allowed cycle still advances. Abort
  // is applied last so it overrides every other decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = MEM;
      end
      MEM: begin
        if (bus.stage_done[0] && dwell_ok) state_d = PE;
        else if (timeout_hit)              state_d = ERR;
      end
      PE: begin
        if (bus.stage_done[1] && dwell_ok) state_d = C3;
        else if (timeout_hit)              state_d = ERR;
      end
      C3: begin
        if (bus.stage_done[2] && dwell_ok) state_d = C2;
        else if (timeout_hit)              state_d = ERR;
      end
      C2: begin
        if (bus.stage_done[3] && dwell_ok) state_d = DISP;
        else if (timeout_hit)              state_d = ERR;
      end
      DISP: begin
        if (bus.start) state_d = MEM;
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (bus.abort) state_d = IDLE;
  end

  // Dwell counter restarts on every transition and otherwise counts up,
  // sticking at its maximum rather than wrapping back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state so that once registered they
  // change on the same edge as the state register.
  always_comb begin
    hold_d  = HOLD_ALL;
    busy_d  = 1'b0;
    phase_d = state_d;
    error_d = TIMEOUT_EN && (state_d == ERR);
    case (state_d)
      MEM: begin
        hold_d = HOLD_MEM;
        busy_d = 1'b1;
      end
      PE: begin
        hold_d = HOLD_PE;
        busy_d = 1'b1;
      end
      C3: begin
        hold_d = HOLD_C3;
        busy_d = 1'b1;
      end
      C2: begin
        hold_d = HOLD_C2;
        busy_d = 1'b1;
      end
      DISP: begin
        hold_d = HOLD_NONE;
      end
      default: begin
        hold_d = HOLD_ALL;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= HOLD_ALL;
      phase_q <= 3'd0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  assign bus.rst_mem  = hold_q[4];
  assign bus.rst_pe   = hold_q[3];
  assign bus.rst_3b3  = hold_q[2];
  assign bus.rst_2b2  = hold_q[1];
  assign bus.rst_disp = hold_q[0];
  assign bus.phase    = phase_q;
  assign bus.busy     = busy_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_phase_sequencer
//
// Purpose: directed, self-checking bench for phase_sequencer. A table of
// single-cycle vectors walks a normal run; hand-written sequences cover the
// fast path, abort, watchdog (or its absence) and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_phase_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  phase_sequencer_if bus();

  phase_sequencer #(
    .TIMEOUT(16),
    .CNT_W  (24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       start;
    logic       abort;
    logic [3:0] done;
    logic [2:0] ph;
    logic [4:0] hold;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs [20];

  // Expected trajectory when every stage_done bit is held high, starting
  // the cycle after MEM was entered.
  logic [2:0] fast_ph   [8] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5};
  logic [4:0] fast_hold [8] = '{5'b01111, 5'b00111, 5'b00111, 5'b00011,
                                5'b00011, 5'b00001, 5'b00001, 5'b00000};
  logic       fast_busy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic s, input logic a, input logic [3:0] d);
    bus.start      = s;
    bus.abort      = a;
    bus.stage_done = d;
  endtask

  task automatic check_output(input string name, input logic [2:0] ph,
                              input logic [4:0] hold, input logic busy,
                              input logic err);
    logic [4:0] act_hold;
    act_hold = {bus.rst_mem, bus.rst_pe, bus.rst_3b3, bus.rst_2b2, bus.rst_disp};
    checks++;
    if (bus.phase !== ph || act_hold !== hold || bus.busy !== busy || bus.error !== err) begin
      errors++;
      $display("[TB] FAIL %s: got phase=%0d hold=%b busy=%b err=%b, expected phase=%0d hold=%b busy=%b err=%b",
               name, bus.phase, act_hold, bus.busy, bus.error, ph, hold, busy, err);
    end
  endtask

  task automatic do_reset(input logic [3:0] d);
    apply_stimulus(1'b0, 1'b0, d);
    rst = 1'b0;
    repeat (2) tick();
    check_output("reset_state", 3'd0, 5'b11111, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic check_fast_stages(input string tag);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_output($sformatf("%s_step%0d", tag, k + 1), fast_ph[k], fast_hold[k],
                   fast_busy[k], 1'b0);
    end
  endtask

  // Drives a run with only the mem done bit set until PE has been entered.
  task automatic run_to_pe();
    apply_stimulus(1'b1, 1'b0, 4'b0001);
    tick();
    check_output("tmo_mem", 3'd1, 5'b01111, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'b0001);
    tick();
    tick();
    check_output("tmo_pe_entry", 3'd2, 5'b00111, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    apply_stimulus(1'b0, 1'b0, 4'h0);

    //            start abort done    phase  hold      busy err
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 3'd1, 5'b01111, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'h0, 3'd1, 5'b01111, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 4'h0, 3'd1, 5'b01111, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'h0, 3'd1, 5'b01111, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'h1, 3'd2, 5'b00111, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'h2, 3'd2, 5'b00111, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'hD, 3'd2, 5'b00111, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 3'd2, 5'b00111, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'h2, 3'd3, 5'b00011, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, 3'd3, 5'b00011, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 3'd3, 5'b00011, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 4'h0, 3'd3, 5'b00011, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 4'h4, 3'd4, 5'b00001, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 4'h0, 3'd4, 5'b00001, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 4'h0, 3'd4, 5'b00001, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 4'h0, 3'd4, 5'b00001, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 4'h8, 3'd5, 5'b00000, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 4'h0, 3'd5, 5'b00000, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 4'hF, 3'd5, 5'b00000, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 4'h0, 3'd1, 5'b01111, 1'b1, 1'b0};

    $display("[TB] reset and normal run");
    do_reset(4'h0);
    check_output("idle_after_release", 3'd0, 5'b11111, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      apply_stimulus(vecs[i].start, vecs[i].abort, vecs[i].done);
      tick();
      check_output($sformatf("vec%0d", i), vecs[i].ph, vecs[i].hold,
                   vecs[i].busy, vecs[i].err);
    end

    $display("[TB] rerun completes with all done flags high");
    apply_stimulus(1'b0, 1'b0, 4'hF);
    check_fast_stages("rerun");

    $display("[TB] early done held from reset");
    do_reset(4'hF);
    check_output("idle_done_held", 3'd0, 5'b11111, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 4'hF);
    tick();
    check_output("early_mem", 3'd1, 5'b01111, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'hF);
    check_fast_stages("early");

    $display("[TB] abort in C3 together with start");
    do_reset(4'h0);
    apply_stimulus(1'b1, 1'b0, 4'hF);
    tick();
    apply_stimulus(1'b0, 1'b0, 4'hF);
    repeat (4) tick();
    apply_stimulus(1'b0, 1'b0, 4'h0);
    check_output("abort_in_c3", 3'd3, 5'b00011, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 4'h0);
    tick();
    check_output("abort_to_idle", 3'd0, 5'b11111, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'h0);
    tick();
    check_output("abort_stay_idle", 3'd0, 5'b11111, 1'b0, 1'b0);

`ifdef PHASE_SEQ_TIMEOUT_EN
    $display("[TB] watchdog on a stalled PE stage");
    do_reset(4'h0);
    run_to_pe();
    repeat (15) tick();
    check_output("tmo_pe_last", 3'd2, 5'b00111, 1'b1, 1'b0);
    tick();
    check_output("tmo_err", 3'd6, 5'b11111, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'h0);
    tick();
    check_output("tmo_err_start", 3'd6, 5'b11111, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 4'h0);
    tick();
    check_output("tmo_abort", 3'd0, 5'b11111, 1'b0, 1'b0);

    $display("[TB] done on the last allowed cycle beats the watchdog");
    apply_stimulus(1'b0, 1'b0, 4'h0);
    run_to_pe();
    repeat (15) tick();
    apply_stimulus(1'b0, 1'b0, 4'b0011);
    tick();
    check_output("tmo_done_wins", 3'd3, 5'b00011, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'h0);
    tick();
    apply_stimulus(1'b0, 1'b0, 4'h0);
`else
    $display("[TB] stalled PE stage waits without watchdog");
    do_reset(4'h0);
    run_to_pe();
    repeat (40) tick();
    check_output("nowdt_pe_wait", 3'd2, 5'b00111, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 4'b0001);
    tick();
    check_output("nowdt_start_ignored", 3'd2, 5'b00111, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'h0);
    tick();
    check_output("nowdt_abort", 3'd0, 5'b11111, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'h0);
`endif

    $display("[TB] asynchronous reset mid C2");
    do_reset(4'h0);
    apply_stimulus(1'b1, 1'b0, 4'hF);
    tick();
    apply_stimulus(1'b0, 1'b0, 4'hF);
    repeat (6) tick();
    apply_stimulus(1'b0, 1'b0, 4'h0);
    check_output("async_in_c2", 3'd4, 5'b00001, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_output("async_reset_values", 3'd0, 5'b11111, 1'b0, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    check_output("async_wait_start", 3'd0, 5'b11111, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 4'h0);
    tick();
    check_output("async_restart", 3'd1, 5'b01111, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 100000: cycles a stage may run before it is declared hung; legal range 2..2^24-1.
REQ-002 The block SHALL have parameter CNT_W, default 24: width of the dwell/timeout counter.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin or restart the pipeline run.
REQ-006 The block SHALL have port abort  input  1  forces an immediate return to IDLE.
REQ-007 The block SHALL have port stage_done  input  4  completion flags: bit0 mem, bit1 pe, bit2 3b3, bit3 2b2; level, active-high.
REQ-008 The block SHALL have ports rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp  output  1 each  stage hold; 1 = stage held in reset.
REQ-009 The block SHALL have port phase  output  3  encoded current state.
REQ-010 The block SHALL have ports busy, error  output  1 each  run in progress; hang detected.

Function
REQ-011 States and phase encodings SHALL be IDLE=0, MEM=1, PE=2, C3=3, C2=4, DISP=5, ERR=6; code 7 is illegal.
REQ-012 Stage holds SHALL be: IDLE and ERR all 1; MEM 01111; PE 00111; C3 00011; C2 00001; DISP 00000 (order mem,pe,3b3,2b2,disp).
REQ-013 All outputs SHALL be registered and SHALL change in the same cycle as the state register.
REQ-014 IDLE SHALL go to MEM on the edge where start=1.
REQ-015 In MEM/PE/C3/C2, the state SHALL advance to the next state when the matching stage_done bit is 1 and dwell counter >= 1.
REQ-016 stage_done SHALL be ignored in the first cycle of each stage, so the minimum dwell is 2 cycles.
REQ-017 The dwell counter SHALL clear on every state change and otherwise increment, saturating at 2^CNT_W-1.
REQ-018 DISP SHALL be held indefinitely; start in DISP SHALL go to MEM (rerun).
REQ-019 start SHALL be ignored in MEM, PE, C3, C2 and ERR.
REQ-020 abort=1 SHALL go to IDLE from any state, with priority over start, stage_done and timeout.
REQ-021 ERR SHALL be left only via abort, then to IDLE; error=1 SHALL be asserted only in ERR.
REQ-022 busy SHALL be 1 in MEM, PE, C3 and C2, and 0 otherwise.
REQ-023 If done and timeout occur in the same cycle, done SHALL win and the state advances.
REQ-024 An illegal state code SHALL go to IDLE on the next edge.

Reset
REQ-025 While rst=0 the state SHALL be IDLE, the counter 0, rst_mem=rst_pe=rst_3b3=rst_2b2=rst_disp=1, phase=0, and busy=error=0.
REQ-026 Reset SHALL take effect asynchronously, including mid-run, and release SHALL be synchronous to clk.

Configuration
REQ-027 The timeout feature SHALL be controlled by macro PHASE_SEQ_TIMEOUT_EN.
REQ-028 With PHASE_SEQ_TIMEOUT_EN defined, a stage state SHALL go to ERR when the counter reaches TIMEOUT-1 without a qualifying done.
REQ-029 Without PHASE_SEQ_TIMEOUT_EN, ERR SHALL be unreachable, error SHALL be tied to 0, and stages SHALL wait forever.

Verification
REQ-030 Normal run: start pulse with each stage_done raised 3 cycles after state entry -> phase 1,2,3,4,5 with each state held 4 cycles, outputs exactly per REQ-012, and busy=0 in DISP.
REQ-031 Early done: stage_done=4'hF held from reset, then start -> each stage lasts exactly 2 cycles and DISP is reached 8 cycles after start is sampled.
REQ-032 Timeout: TIMEOUT=16 with PHASE_SEQ_TIMEOUT_EN defined, start, pe done never raised -> ERR 16 cycles after entering PE, error=1, all holds 1; a start pulse is ignored; abort -> IDLE.
REQ-033 Abort mid-run: abort in C3 with start asserted the same cycle -> IDLE next edge with phase=0 and all holds 1.
REQ-034 Rerun: start in DISP -> MEM next edge with holds 01111; a second full run completes.
REQ-035 Async reset: rst driven low mid-C2, between clock edges -> outputs reach their reset values before the next clk edge; the run restarts only on a new start.
